// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mult_pkg;

    localparam int unsigned MULT_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Bits needed to hold an iteration count of 0..width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_ctrl.sv
// Control FSM for mult_seq_n: IDLE/RUN/DONE sequencing, iteration
// counter, busy/done generation and datapath strobes.
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic early_exit,
    output logic busy,
    output logic done,
    output logic accept,
    output logic step,
    output logic finish
);

    localparam int unsigned CW = cnt_width(WIDTH);

    mult_state_t   state;
    logic [CW-1:0] cnt;

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign accept = start && ((state == IDLE) || (state == DONE));
    assign finish = (state == RUN) && ((cnt == '0) || early_exit);
    assign step   = (state == RUN) && !finish;

    // State and counter update; a start in RUN is ignored by construction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        cnt   <= CW'(WIDTH);
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (finish) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mult_seq_n.sv
// Sequential shift-add multiplier, signed or unsigned, full 2*WIDTH result.
// Operand magnitudes are multiplied and the sign is applied at the end.
// Optional build macro: MULT_EARLY_EXIT_EN (finish as soon as the
// remaining multiplier bits are all zero; products are unchanged).
module mult_seq_n
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic               neg;
    logic               accept;
    logic               step;
    logic               finish;
    logic               early_exit;

`ifdef MULT_EARLY_EXIT_EN
    assign early_exit = (mplier == '0);
`else
    assign early_exit = 1'b0;
`endif

    mult_ctrl #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .early_exit (early_exit),
        .busy       (busy),
        .done       (done),
        .accept     (accept),
        .step       (step),
        .finish     (finish)
    );

    // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1) as an unsigned value.
    always_comb begin
        a_mag = a;
        b_mag = b;
        if (is_signed && a[WIDTH-1]) a_mag = -a;
        if (is_signed && b[WIDTH-1]) b_mag = -b;
    end

    // Datapath registers: load on accept, shift-add per step, sign-fix on finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else if (accept) begin
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            acc    <= '0;
            neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (step) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end else if (finish) begin
            product <= neg ? -acc : acc;
        end
    end

endmodule

// File: tb/tb_mult_seq_n.sv
// Self-checking bench for mult_seq_n (WIDTH=32, fixed-latency build).
module tb_mult_seq_n;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           is_signed;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit           sgn;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [63:0]  exp;
    } vec_t;

    mult_seq_n #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Count edges after the accepting edge until done is seen (bounded).
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done && cyc < 200);
    endtask

    // Called at #1 after a posedge with the block ready.
    task automatic run_op(input string name, input vec_t v);
        int cyc;
        is_signed = v.sgn;
        a         = v.a;
        b         = v.b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc);
        check({name, " latency"}, 64'(cyc), 64'(LAT));
        check({name, " product"}, product, v.exp);
        @(posedge clk);
        #1;
        check({name, " done width"}, 64'(done), 64'd0);
        check({name, " product hold"}, product, v.exp);
    endtask

    vec_t vecs[12];

    initial begin
        int  cyc;
        bit  seen;
        bit  held;

        vecs[0]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[1]  = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1};
        vecs[2]  = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[3]  = '{1'b0, 32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000};
        vecs[4]  = '{1'b0, 32'h0000_0002, 32'h8000_0000, 64'h0000_0001_0000_0000};
        vecs[5]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vecs[6]  = '{1'b0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
        vecs[7]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9};
        vecs[8]  = '{1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000};
        vecs[9]  = '{1'b0, 32'h8000_0000, 32'h0000_0001, 64'h0000_0000_8000_0000};
        vecs[10] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
        vecs[11] = '{1'b0, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780};

        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset product", product, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Start during RUN (at edge 5) with other operands must be ignored.
        is_signed = 1'b0;
        a = 32'd3;
        b = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 4) begin
                start = 1'b1;
                a = 32'd9;
                b = 32'd9;
            end
            if (cyc == 5) start = 1'b0;
        end while (!done && cyc < 200);
        check("ignored start latency", 64'(cyc), 64'(LAT));
        check("ignored start product", product, 64'd15);
        @(posedge clk);
        #1;

        // Reset at edge 10 aborts the operation; no done afterwards.
        a = 32'd11;
        b = 32'd13;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort product", product, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("abort no done", 64'(seen), 64'd0);

        // First start after reset behaves normally.
        run_op("post reset", '{1'b0, 32'd6, 32'd7, 64'd42});

        // Back-to-back: start held high through DONE.
        is_signed = 1'b0;
        a = 32'd100;
        b = 32'd200;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 32'd10;
        b = 32'd10;
        wait_done(cyc);
        check("b2b first latency", 64'(cyc), 64'(LAT));
        check("b2b first product", product, 64'd20000);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b second accepted", 64'(busy), 64'd1);
        check("b2b done width", 64'(done), 64'd0);
        held = 1'b1;
        cyc = 0;
        while (!done && cyc < 200) begin
            if (product !== 64'd20000) held = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("b2b product held in run", 64'(held), 64'd1);
        check("b2b second latency", 64'(cyc), 64'(LAT));
        check("b2b second product", product, 64'd100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_seq_n.md
MULT_SEQ_N -- requirements
Module: mult_seq_n

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits; legal range 4..64.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a multiply; sampled only when the block is ready.
REQ-005 is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 a  input  WIDTH  multiplicand; sampled with start.
REQ-007 b  input  WIDTH  multiplier; sampled with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking a valid new product.
REQ-010 product  output  2*WIDTH  full-width result; holds until the next done.

Function
REQ-011 FSM states SHALL be IDLE, RUN and DONE; busy SHALL be 1 only in RUN, and done SHALL be 1 only in DONE.
REQ-012 Start SHALL be accepted in IDLE or DONE; at the accepting edge the block SHALL latch |a|, |b| and neg = is_signed&(a[MSB]^b[MSB]), clear the accumulator, load counter=WIDTH and enter RUN.
REQ-013 Start while in RUN SHALL be ignored, with no effect on state or operands.
REQ-014 Each RUN edge with counter>0 SHALL:
  - add the shifted multiplicand (2*WIDTH bits, zero-extended) into the accumulator if the multiplier LSB is 1;
  - shift the multiplicand left 1;
  - shift the multiplier right 1;
  - decrement the counter.
REQ-015 The RUN edge with counter==0 SHALL write product = neg ? -acc : acc (mod 2^(2*WIDTH)) and enter DONE.
REQ-016 Without early exit, done SHALL be high in the cycle after edge WIDTH+1, where edge 0 is the accepting edge.
REQ-017 DONE SHALL last exactly one cycle, then go to IDLE unless a start is accepted.
REQ-018 A back-to-back start accepted in DONE SHALL enter RUN, and product SHALL stay valid during RUN.
REQ-019 Magnitude of -2^(WIDTH-1) SHALL be 2^(WIDTH-1), held unsigned with no overflow; signed results SHALL be exact in 2*WIDTH bits.
REQ-020 All arithmetic SHALL be carry-free modulo 2^(2*WIDTH); there are no overflow flags.

Reset
REQ-021 With reset high at an edge: state=IDLE; busy=0, done=0, product=0; accumulator, operand registers and counter SHALL be 0.
REQ-022 Reset SHALL override start and any in-progress operation; an aborted operation SHALL never assert done.
REQ-023 After reset deasserts, the first start SHALL be accepted normally.

Configuration
REQ-024 Macro MULT_EARLY_EXIT_EN SHALL select early termination.
REQ-025 When MULT_EARLY_EXIT_EN is defined, a RUN edge with the multiplier register ==0 SHALL take the counter==0 action (REQ-015) regardless of the counter.
  - done follows edge 1 for b==0;
  - otherwise done follows edge msb_index(|b|)+2.
REQ-026 When MULT_EARLY_EXIT_EN is undefined, latency SHALL be fixed at WIDTH+1 edges for all operands.
REQ-027 Product values SHALL be identical in both builds.

Structure
REQ-028 Shared package mult_pkg SHALL hold:
  - the FSM state enum (IDLE/RUN/DONE);
  - MULT_WIDTH_DEFAULT=32;
  - a counter-width function returning clog2(WIDTH+1).
REQ-029 A sub-module mult_ctrl SHALL contain the FSM, counter, and busy/done generation; the datapath (abs, shift, add, negate, registers) SHALL stay in mult_seq_n.
REQ-030 Reuse existing codebase adder and mux library cells where widths permit.

Verification
REQ-031 WIDTH=32, unsigned, a=b=0xFFFFFFFF -> product=0xFFFFFFFE00000001, done one cycle, following edge 33 (fixed-latency build).
REQ-032 Signed, a=-3 (0xFFFFFFFD), b=5 -> product=0xFFFFFFFFFFFFFFF1; signed a=b=0x80000000 -> product=0x4000000000000000.
REQ-033 Start again at edge 5 of a running operation, with different operands -> ignored; the original result completes on time.
REQ-034 Reset high at edge 10 of an operation -> next cycle busy=0, done=0, product=0; no done pulse follows.
REQ-035 Back-to-back: start held high through DONE -> second operation accepted at the DONE edge; the first product remains on the output until the second done.
REQ-036 MULT_EARLY_EXIT_EN build: b=0 -> done after edge 1, product=0; b=1, a=7 -> done after edge 2, product=7; unsigned b=0x80000000, a=2 -> done after edge 33, product=0x100000000.
